// File: rtl/serial_mag_comparator_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: FSM state codes,
// result-vector indices and a helper that builds the one-hot result.
package cmp_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int R_GT = 0;
  localparam int R_EQ = 1;
  localparam int R_LT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

  typedef logic [2:0] res_t;

  // eq is implied whenever neither sticky flag fired, keeping the result one-hot.
  function automatic res_t pack_result(input logic g, input logic l);
    res_t r;
    r       = 3'b000;
    r[R_GT] = g;
    r[R_LT] = l;
    r[R_EQ] = ~g & ~l;
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Operand and result handshakes of serial_mag_comparator.
// master = producer/consumer side, slave = comparator side.
interface serial_mag_comparator_if #(parameter int WIDTH = 8) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gt, eq, lt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gt, eq, lt
  );

endinterface

// File: rtl/serial_mag_comparator_bit_cell.sv
// Combinational 1-bit magnitude compare cell used by the serial walker.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a_bit & ~b_bit;
  assign lt = ~a_bit & b_bit;
  assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready in and out.
// Optional macro EARLY_EXIT_EN: finish on the first differing bit.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gt_s_q, gt_s_d;
  logic               lt_s_q, lt_s_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  res_t               res_q, res_d;

  logic cell_gt, cell_eq, cell_lt;
  logic hit_gt, hit_lt, finish;

  cmp_bit_cell u_cell (
    .a_bit (a_q[cnt_q]),
    .b_bit (b_q[cnt_q]),
    .gt    (cell_gt),
    .eq    (cell_eq),
    .lt    (cell_lt)
  );

  // Once a flag is set the other can no longer fire: the first difference wins.
  assign hit_gt = gt_s_q | (~lt_s_q & cell_gt);
  assign hit_lt = lt_s_q | (~gt_s_q & cell_lt);

`ifdef EARLY_EXIT_EN
  assign finish = (cnt_q == CNT_W'(0)) | (~cell_eq & ~gt_s_q & ~lt_s_q);
`else
  assign finish = (cnt_q == CNT_W'(0));
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    gt_s_d      = gt_s_q;
    lt_s_d      = lt_s_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          cnt_d      = CNT_W'(WIDTH - 1);
          gt_s_d     = 1'b0;
          lt_s_d     = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_SHIFT;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        gt_s_d = hit_gt;
        lt_s_d = hit_lt;
        if (finish) begin
          cnt_d       = CNT_W'(0);
          res_d       = pack_result(hit_gt, hit_lt);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          res_d       = 3'b000;
          gt_s_d      = 1'b0;
          lt_s_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        res_d       = 3'b000;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cnt_q       <= CNT_W'(0);
      gt_s_q      <= 1'b0;
      lt_s_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      gt_s_q      <= gt_s_d;
      lt_s_q      <= lt_s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.gt        = res_q[R_GT];
  assign bus.eq        = res_q[R_EQ];
  assign bus.lt        = res_q[R_LT];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed-vector bench for serial_mag_comparator (WIDTH=8), both EARLY_EXIT_EN settings.
module tb_serial_mag_comparator;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

`ifdef EARLY_EXIT_EN
  localparam int LAT_MSB_DIFF = 1;
`else
  localparam int LAT_MSB_DIFF = 8;
`endif

  serial_mag_comparator_if #(.WIDTH(8)) bus ();

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction; exp_res is {gt,eq,lt}; hold = cycles out_ready stays low.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] exp_res, input int exp_lat, input int hold);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.in_valid = 1'b0;
        bus.a        = ~av;
        bus.b        = ~bv;
      end
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = i - 1;
      end
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, exp_res});
    chk({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'h00;
      bus.b        = 8'hFF;
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_res"}, {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, exp_res});
      chk({tag, "_hold_rdy"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_rel_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_rel_res"}, {29'd0, bus.gt, bus.eq, bus.lt}, 32'd0);
    chk({tag, "_rel_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int vcount;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_res", {29'd0, bus.gt, bus.eq, bus.lt}, 32'd0);
    rst_n = 1'b1;

    run_cmp("eq_a5", 8'hA5, 8'hA5, EQ, 8, 0);
    run_cmp("gt_80", 8'h80, 8'h7F, GT, LAT_MSB_DIFF, 0);
    run_cmp("lt_12", 8'h12, 8'h13, LT, 8, 0);
    run_cmp("lt_7f", 8'h7F, 8'h80, LT, LAT_MSB_DIFF, 0);
    run_cmp("hold_f0", 8'hF0, 8'h0F, GT, LAT_MSB_DIFF, 5);

    // Stray in_valid during DONE must not have started a new compare.
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("hold_no_extra", vcount, 0);

    // Reset during the third SHIFT cycle discards the compare.
    @(negedge clk);
    bus.a        = 8'h55;
    bus.b        = 8'h55;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_res", {29'd0, bus.gt, bus.eq, bus.lt}, 32'd0);
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("midrst_no_pulse", vcount, 0);

    run_cmp("gt_01", 8'h01, 8'h00, GT, 8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
